// File: rtl/sdc_cmd_framer_if.sv
// Command request handshake between a host-side requester and the SD command framer.
`timescale 1ns/1ps
interface sdc_cmd_framer_if;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_index, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_index, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/sdc_cmd_framer.sv
// SD command framer: latches index/arg, computes CRC7 serially, then paces
// loadCmd/shiftCmd strobes so the downstream 48-bit shift register drives the CMD line.
`timescale 1ns/1ps
module sdc_cmd_framer #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    sdc_cmd_framer_if.slave    cmd,
    output logic [47:0]        fullCmd,
    output logic               loadCmd,
    output logic               shiftCmd,
    output logic               bit_tick,
    output logic               cmd_done,
    output logic               busy
);
    // state        | meaning
    // S_IDLE       | ready, waiting for cmd_valid
    // S_CRC        | one header bit per clk into CRC7 (40 clks)
    // S_WAIT_TICK  | frame built, waiting for bit_tick to load it
    // S_SHIFT      | one shift strobe per bit_tick, 48 in total
    // S_DONE       | cmd_done pulse issued, returning to idle
    typedef enum logic [2:0] {S_IDLE, S_CRC, S_WAIT_TICK, S_SHIFT, S_DONE} state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    state_t         state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic           bit_tick_q, bit_tick_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     crc_q, crc_d;
    logic [5:0]     idx_q, idx_d;
    logic [31:0]    arg_q, arg_d;
    logic [47:0]    full_cmd_q, full_cmd_d;
    logic           load_q, load_d;
    logic           shift_q, shift_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;

    logic [39:0]    hdr;
    logic [5:0]     hdr_sel;
    logic           crc_fb;
    logic [6:0]     crc_step;

    always_comb begin
        div_cnt_d  = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_ONE;
        bit_tick_d = (div_cnt_d == DIV_MAX);

        hdr      = {2'b01, idx_q, arg_q};
        hdr_sel  = 6'd39 - bit_cnt_q;
        crc_fb   = hdr[hdr_sel] ^ crc_q[6];
        crc_step = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        full_cmd_d = full_cmd_q;
        ready_d    = ready_q;
        load_d     = 1'b0;
        shift_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    idx_d     = cmd.cmd_index;
                    arg_d     = cmd.cmd_arg;
                    crc_d     = 7'h00;
                    bit_cnt_d = 6'd0;
                    ready_d   = 1'b0;
                    state_d   = S_CRC;
                end
            end
            S_CRC: begin
                crc_d = crc_step;
                if (bit_cnt_q == 6'd39) begin
                    full_cmd_d = {2'b01, idx_q, arg_q, crc_step, 1'b1};
                    bit_cnt_d  = 6'd0;
                    state_d    = S_WAIT_TICK;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            S_WAIT_TICK: begin
                // strobes are registered, so they are timed off the next-cycle tick
                if (bit_tick_d) begin
                    load_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == 6'd48) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (bit_tick_d) begin
                    shift_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_tick_q <= 1'b0;
            bit_cnt_q  <= 6'd0;
            crc_q      <= 7'h00;
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            full_cmd_q <= 48'hFFFF_FFFF_FFFF;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_tick_q <= bit_tick_d;
            bit_cnt_q  <= bit_cnt_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            full_cmd_q <= full_cmd_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign busy          = ~ready_q;
    assign fullCmd       = full_cmd_q;
    assign loadCmd       = load_q;
    assign shiftCmd      = shift_q;
    assign bit_tick      = bit_tick_q;
    assign cmd_done      = done_q;
endmodule
